// File: rtl/cpu_defs.sv
// Shared pipeline definitions: forwarding select codes, Tnew/Tuse width,
// multiply/divide latencies and the E-stage hazard record.
package cpu_defs;
  localparam int T_W      = 2;
  localparam int MD_CNT_W = 4;

  typedef logic [T_W-1:0] tt_t;
  typedef logic [1:0]     fsel_t;

  localparam fsel_t FWD_GRF = 2'd0;
  localparam fsel_t FWD_EM  = 2'd1;
  localparam fsel_t FWD_MW  = 2'd2;

  localparam logic [MD_CNT_W-1:0] MD_MULT_LAT = 4'd5;
  localparam logic [MD_CNT_W-1:0] MD_DIV_LAT  = 4'd10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] wa;
    tt_t        tnew;
    logic       md_start;
    logic       md_div;
  } e_rec_t;

  // Remaining cycles until a result exists, one stage further down the pipe.
  function automatic tt_t tnew_dec(tt_t t);
    return (t == '0) ? '0 : tt_t'(t - 1'b1);
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage instruction description in, stall/forward/MD-busy decisions out.
interface hazard_ctrl_if;
  logic               d_valid;
  logic [4:0]         d_rs;
  logic [4:0]         d_rt;
  logic               d_use_rs;
  logic               d_use_rt;
  cpu_defs::tt_t      d_tuse_rs;
  cpu_defs::tt_t      d_tuse_rt;
  logic [4:0]         d_wa;
  cpu_defs::tt_t      d_tnew;
  logic               d_md_start;
  logic               d_md_div;
  logic               d_md_use;
  logic               stall;
  cpu_defs::fsel_t    fwd_rs_d;
  cpu_defs::fsel_t    fwd_rt_d;
  cpu_defs::fsel_t    fwd_rs_e;
  cpu_defs::fsel_t    fwd_rt_e;
  logic               md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_wa, d_tnew, d_md_start, d_md_div, d_md_use,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
           d_wa, d_tnew, d_md_start, d_md_div, d_md_use,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );
endinterface

// File: rtl/md_busy_counter.sv
// Multiply/divide occupancy counter: loaded when an MD op leaves E, counts down to 0.
module md_busy_counter
  import cpu_defs::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                is_div,
  output logic [MD_CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (start)
      count <= is_div ? MD_DIV_LAT : MD_MULT_LAT;
    else if (count != '0)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Tnew/Tuse hazard unit: stall decision, D/E-stage forwarding selects and
// MD-unit busy tracking from the E/M/W producer records.
module hazard_ctrl
  import cpu_defs::*;
(
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  e_rec_t                e_p0;
  logic [4:0]            m_wa_p1;
  tt_t                   m_tnew_p1;
  logic [4:0]            w_wa_p2;
  logic [MD_CNT_W-1:0]   md_cnt;
  logic                  md_busy_w;
  logic                  haz_rs, haz_rt, haz_md;
  logic                  unused_e;

  function automatic logic src_haz(logic [4:0] src, logic used, tt_t tuse,
                                   logic [4:0] ewa, tt_t etn,
                                   logic [4:0] mwa, tt_t mtn);
    return used && (src != 5'd0) &&
           (((ewa == src) && (etn > tuse)) || ((mwa == src) && (mtn > tuse)));
  endfunction

  function automatic fsel_t sel_d(logic [4:0] src, logic [4:0] ewa, tt_t etn,
                                  logic [4:0] mwa, tt_t mtn);
    if (src == 5'd0)                      return FWD_GRF;
    if ((ewa == src) && (etn == '0))      return FWD_EM;
    if ((mwa == src) && (mtn == '0))      return FWD_MW;
    return FWD_GRF;
  endfunction

  function automatic fsel_t sel_e(logic [4:0] src, logic [4:0] mwa, tt_t mtn,
                                  logic [4:0] wwa);
    if (src == 5'd0)                      return FWD_GRF;
    if ((mwa == src) && (mtn == '0))      return FWD_EM;
    if (wwa == src)                       return FWD_MW;
    return FWD_GRF;
  endfunction

  md_busy_counter u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (e_p0.md_start),
    .is_div (e_p0.md_div),
    .count  (md_cnt)
  );

  // Combinational decisions from the registered records and the D inputs
  assign md_busy_w = (md_cnt != '0) || e_p0.md_start;
  assign haz_rs = src_haz(hz.d_rs, hz.d_use_rs, hz.d_tuse_rs,
                          e_p0.wa, e_p0.tnew, m_wa_p1, m_tnew_p1);
  assign haz_rt = src_haz(hz.d_rt, hz.d_use_rt, hz.d_tuse_rt,
                          e_p0.wa, e_p0.tnew, m_wa_p1, m_tnew_p1);
  assign haz_md = hz.d_md_use && md_busy_w;

  assign hz.stall    = hz.d_valid && (haz_rs || haz_rt || haz_md);
  assign hz.md_busy  = md_busy_w;
  assign hz.fwd_rs_d = sel_d(hz.d_rs, e_p0.wa, e_p0.tnew, m_wa_p1, m_tnew_p1);
  assign hz.fwd_rt_d = sel_d(hz.d_rt, e_p0.wa, e_p0.tnew, m_wa_p1, m_tnew_p1);
  assign hz.fwd_rs_e = sel_e(e_p0.rs, m_wa_p1, m_tnew_p1, w_wa_p2);
  assign hz.fwd_rt_e = sel_e(e_p0.rt, m_wa_p1, m_tnew_p1, w_wa_p2);

  // Recorded for pipeline visibility; decisions do not depend on them
  assign unused_e = ^{e_p0.valid, e_p0.use_rs, e_p0.use_rt};

  // D -> E -> M -> W record advance; a stalled or empty slot becomes a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      e_p0      <= '0;
      m_wa_p1   <= '0;
      m_tnew_p1 <= '0;
      w_wa_p2   <= '0;
    end else begin
      w_wa_p2   <= m_wa_p1;
      m_wa_p1   <= e_p0.wa;
      m_tnew_p1 <= tnew_dec(e_p0.tnew);
      if (!hz.stall && hz.d_valid)
        e_p0 <= '{valid: 1'b1, rs: hz.d_rs, rt: hz.d_rt,
                  use_rs: hz.d_use_rs, use_rt: hz.d_use_rt,
                  wa: hz.d_wa, tnew: hz.d_tnew,
                  md_start: hz.d_md_start, md_div: hz.d_md_div};
      else
        e_p0 <= '0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios followed by random instruction streams, every cycle checked
// against a time-indexed issue-history model of the hazard rules.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  // One entry per cycle: the instruction that spent that cycle in E
  typedef struct {
    bit v;
    int rs, rt;
    bit urs, urt;
    int wa, tnew;
    bit mds, mdd;
  } ins_t;

  ins_t hist [0:4095];
  int   c;
  int   floor_c;
  int   checks = 0;
  int   errors = 0;
  bit   exp_stall;

  function automatic ins_t bubble();
    ins_t b;
    b = '{v: 0, rs: 0, rt: 0, urs: 0, urt: 0, wa: 0, tnew: 0, mds: 0, mdd: 0};
    return b;
  endfunction

  function automatic ins_t at(int t);
    if (t < 0 || t <= floor_c) return bubble();
    return hist[t];
  endfunction

  // Cycles still needed at time now for a result issued into E at time t
  function automatic int rem(int t, int tn, int now);
    int r;
    r = t + tn - now;
    return (r > 0) ? r : 0;
  endfunction

  function automatic bit m_haz(int src, bit u, int tuse);
    ins_t p;
    if (!u || src == 0) return 0;
    for (int a = 0; a < 2; a++) begin
      p = at(c - a);
      if (p.wa == src && rem(c - a, p.tnew, c) > tuse) return 1;
    end
    return 0;
  endfunction

  // Busy if an MD op is in E now, or the most recent one is still within its latency
  function automatic bit m_md_busy();
    if (at(c).mds) return 1;
    for (int t = c - 1; t >= c - 10 && t > floor_c; t--)
      if (hist[t].mds) return (c <= t + (hist[t].mdd ? 10 : 5));
    return 0;
  endfunction

  function automatic int m_fwd_d(int src);
    ins_t p;
    if (src == 0) return 0;
    p = at(c);
    if (p.wa == src && rem(c, p.tnew, c) == 0) return 1;
    p = at(c - 1);
    if (p.wa == src && rem(c - 1, p.tnew, c) == 0) return 2;
    return 0;
  endfunction

  function automatic int m_fwd_e(int src);
    ins_t p;
    if (src == 0) return 0;
    p = at(c - 1);
    if (p.wa == src && rem(c - 1, p.tnew, c) == 0) return 1;
    p = at(c - 2);
    if (p.wa == src) return 2;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setd(input int v, input int rs, input int rt, input int urs, input int urt,
                      input int trs, input int trt, input int wa, input int tn,
                      input int mds, input int mdd, input int mdu);
    hif.d_valid    = v[0];
    hif.d_rs       = rs[4:0];
    hif.d_rt       = rt[4:0];
    hif.d_use_rs   = urs[0];
    hif.d_use_rt   = urt[0];
    hif.d_tuse_rs  = trs[1:0];
    hif.d_tuse_rt  = trt[1:0];
    hif.d_wa       = wa[4:0];
    hif.d_tnew     = tn[1:0];
    hif.d_md_start = mds[0];
    hif.d_md_div   = mdd[0];
    hif.d_md_use   = mdu[0];
  endtask

  task automatic idle();
    setd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sample();
    ins_t e;
    @(negedge clk);
    e = at(c);
    exp_stall = hif.d_valid &&
                (m_haz(int'(hif.d_rs), hif.d_use_rs, int'(hif.d_tuse_rs)) ||
                 m_haz(int'(hif.d_rt), hif.d_use_rt, int'(hif.d_tuse_rt)) ||
                 (hif.d_md_use && m_md_busy()));
    chk("stall",    hif.stall,    exp_stall);
    chk("md_busy",  hif.md_busy,  m_md_busy());
    chk("fwd_rs_d", hif.fwd_rs_d, m_fwd_d(int'(hif.d_rs)));
    chk("fwd_rt_d", hif.fwd_rt_d, m_fwd_d(int'(hif.d_rt)));
    chk("fwd_rs_e", hif.fwd_rs_e, m_fwd_e(e.rs));
    chk("fwd_rt_e", hif.fwd_rt_e, m_fwd_e(e.rt));
  endtask

  task automatic advance();
    ins_t n;
    @(posedge clk);
    n = bubble();
    if (reset) begin
      floor_c = c;
    end else if (!exp_stall && hif.d_valid) begin
      n = '{v: 1, rs: int'(hif.d_rs), rt: int'(hif.d_rt), urs: hif.d_use_rs,
            urt: hif.d_use_rt, wa: int'(hif.d_wa), tnew: int'(hif.d_tnew),
            mds: hif.d_md_start, mdd: hif.d_md_div};
    end
    hist[c + 1] = n;
    c++;
    #1;
  endtask

  initial begin
    int  n;
    bit  done;
    for (int i = 0; i < 4096; i++) hist[i] = bubble();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    c       = 1;
    floor_c = 0;

    // Reset state
    sample();
    chk("rst_stall", hif.stall, 0);
    chk("rst_md_busy", hif.md_busy, 0);
    chk("rst_fwd_rs_e", hif.fwd_rs_e, 0);
    advance();

    // Load then branch on the loaded register
    setd(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0); sample(); advance();
    setd(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    sample(); chk("lw_beq_stall1", hif.stall, 1); advance();
    sample(); chk("lw_beq_stall2", hif.stall, 1); advance();
    sample(); chk("lw_beq_release", hif.stall, 0); chk("lw_beq_fwd", hif.fwd_rs_d, 0); advance();
    idle(); repeat (3) begin sample(); advance(); end

    // ALU result forwarded into E
    setd(1, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0); sample(); advance();
    setd(1, 9, 0, 1, 0, 1, 0, 10, 1, 0, 0, 0);
    sample(); chk("addi_add_stall", hif.stall, 0); advance();
    idle(); sample(); chk("addi_add_fwd_e", hif.fwd_rs_e, 1); advance();
    repeat (3) begin sample(); advance(); end

    // Register 0 is never a hazard
    setd(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0); sample(); advance();
    setd(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    sample(); chk("r0_stall", hif.stall, 0); chk("r0_fwd", hif.fwd_rs_d, 0); advance();
    idle(); repeat (3) begin sample(); advance(); end

    // div immediately followed by mfhi
    setd(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); sample(); advance();
    setd(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    n = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      sample();
      if (hif.stall === 1'b1) begin
        n++;
        chk("div_mfhi_busy", hif.md_busy, 1);
      end else begin
        chk("div_mfhi_busy_fall", hif.md_busy, 0);
        done = 1;
      end
      advance();
    end
    chk("div_mfhi_stall_len", n[7:0], 11);
    idle(); repeat (2) begin sample(); advance(); end

    // Reset while the MD counter sits at 7
    setd(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); sample(); advance();
    setd(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    repeat (4) begin sample(); advance(); end
    reset = 1'b1;
    sample(); chk("md_rst_pre_stall", hif.stall, 1); advance();
    reset = 1'b0;
    sample(); chk("md_rst_busy", hif.md_busy, 0); chk("md_rst_stall", hif.stall, 0); advance();
    idle(); repeat (2) begin sample(); advance(); end

    // Stalled instruction's destination must not reach E
    setd(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0); sample(); advance();
    setd(1, 8, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0);
    sample(); chk("stall_wa_stall", hif.stall, 1); advance();
    setd(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    sample(); chk("stall_wa_no_haz", hif.stall, 0); chk("stall_wa_fwd", hif.fwd_rs_d, 0); advance();
    idle(); repeat (3) begin sample(); advance(); end

    // Random instruction streams
    for (int i = 0; i < 1500; i++) begin
      int mds;
      mds = ($urandom_range(0, 9) == 0) ? 1 : 0;
      reset = ($urandom_range(0, 49) == 0);
      setd(($urandom_range(0, 4) != 0) ? 1 : 0,
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 2), $urandom_range(0, 2),
           $urandom_range(0, 3), $urandom_range(0, 2),
           mds, $urandom_range(0, 1),
           (mds == 1 || $urandom_range(0, 5) == 0) ? 1 : 0);
      sample();
      advance();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
